imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised successor to the decode-stage immediate generator.
- Accepts a raw 32-bit instruction plus a sideband tag over a valid/ready handshake.
- Returns a registered, XLEN-wide, correctly scaled immediate, together with a format code and an illegal flag.
- Sits between fetch/IF-ID register and register-read in ID.
- Adds RV64 support, shift-amount and CSR-zimm formats, bit-0 scaling for B/J, flush, and a 2-entry skid buffer, so ready is registered and throughput is full rate.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64 only.
- TAG_W, 8, width of the opaque sideband (ROB tag / PC index) carried alongside each instruction.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SH.
- out_illegal  out  1  unrecognised encoding.
- out_tag  out  TAG_W  sideband of the entry on the output.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, both entries empty.
- Handshake: a transfer occurs on a rising edge with valid&&ready. The producer holds in_instr/in_tag stable while in_valid && !in_ready. Outputs hold stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, visible in cycle N+1. With out_ready held high, throughput is 1 per cycle.
- Storage: main register (drives outputs) plus skid register.
  - in_ready = !skid_full.
  - Accepting while the main register is occupied and not draining places the entry in the skid register.
  - When main drains, skid moves to main on the same edge.
  - Ordering is strictly FIFO.
- States (2-bit occupancy): EMPTY → ONE on accept. ONE → EMPTY on drain without accept. ONE → TWO on accept without drain. ONE → ONE on simultaneous accept+drain. TWO → ONE on drain; no accept is possible in TWO.
- flush: next state EMPTY. Any same-cycle accept is discarded. in_ready=1 in the following cycle. Flush has priority over all other events.
- Decode is combinational on in_instr and registered into the entry at accept; stored fields are imm, fmt, illegal, tag.
  - opcode 0110011 (R): imm=0, fmt NONE.
  - opcode 0010011 (OP-IMM):
    - funct3 001/101: fmt SH, imm = zero-extended shamt (instr[24:20] for XLEN32, instr[25:20] for XLEN64). XLEN32 with instr[25]=1 → illegal=1.
    - otherwise: fmt I, imm = sign-extended instr[31:20].
  - opcodes 0000011 (load), 1100111 (JALR), 0001111 (FENCE): fmt I.
  - opcode 0011011 (OP-IMM-32): fmt I/SH as above with a 5-bit shamt. Legal only when XLEN=64; otherwise illegal.
  - opcode 0100011 (store): fmt S, imm = sext({instr[31:25], instr[11:7]}).
  - opcode 1100011 (branch): fmt B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - opcodes 0110111/0010111 (LUI/AUIPC): fmt U, imm = sext({instr[31:12], 12'b0}) to XLEN.
  - opcode 1101111 (JAL): fmt J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - opcode 1110011 (SYSTEM):
    - funct3 101/110/111: fmt Z, imm = zero-extended instr[19:15].
    - other funct3: fmt I.
  - Anything else, or instr[1:0] != 2'b11: fmt NONE, imm=0, illegal=1.
- Illegal entries still flow through the handshake; the stage never stalls on them.
- Reset asserted mid-transfer: all entries lost immediately; no output glitches to valid.

Decomposition:
- Shared package/header: opcode constants (extend the existing parameters header), the 3-bit format encoding, and XLEN legality check.
- One sub-module, imm_decode_comb: purely combinational instr → {imm, fmt, illegal}, parametrised by XLEN.
- imm_gen_pipe instantiates imm_decode_comb and owns the skid buffer/FSM.

Test Plan:
- XLEN=32: 0xFFF00093 (addi x1,x0,-1) → next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0. 0xFE000EE3 (beq x0,x0,-4) → out_imm=0xFFFFFFFC, fmt=3.
- XLEN=32: 0x001000EF (jal x1,+2048) → 0x00000800, fmt=5. 0x300FD073 (csrrwi x0,mstatus,31) → 0x0000001F, fmt=6.
- XLEN=64: 0x800000B7 (lui x1,0x80000) → 0xFFFFFFFF80000000, fmt=4. 0x03F09093 (slli x1,x1,63) → 0x3F, fmt=7, illegal=0. Same instruction at XLEN=32 → illegal=1.
- Backpressure: stream 4 instructions with out_ready=0. First accepted, second to skid, in_ready=0 from cycle 2. Release out_ready → all 4 emerge in order, no duplicates or drops.
- Full throughput: in_valid=out_ready=1 for 16 cycles → 16 outputs, in_ready never deasserts.
- Flush with 2 held entries plus a concurrent in_valid → next cycle out_valid=0, in_ready=1, nothing emerges. Async rst_n pulse mid-stream → outputs zero immediately.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - opcodes, format codes, occupancy states and XLEN helper
package imm_gen_pipe_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_SH   = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// rtl/imm_gen_pipe_decode.sv - combinational instruction to immediate/format/illegal decoder
module imm_decode_comb
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] i_imm;
    logic [31:0] v;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3[1:0] == 2'b01);
    assign i_imm    = {{20{instr[31]}}, instr[31:20]};

    // Build a 32-bit value (already sign- or zero-extended) and the format per opcode
    always_comb begin
        v       = 32'd0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    fmt = FMT_NONE;
                end
                OPC_OP_IMM: begin
                    if (is_shift) begin
                        fmt = FMT_SH;
                        if (RV64) begin
                            v = {26'd0, instr[25:20]};
                        end else begin
                            v       = {27'd0, instr[24:20]};
                            illegal = instr[25];
                        end
                    end else begin
                        fmt = FMT_I;
                        v   = i_imm;
                    end
                end
                OPC_OP_IMM_32: begin
                    if (!RV64) begin
                        illegal = 1'b1;
                    end else if (is_shift) begin
                        fmt     = FMT_SH;
                        v       = {27'd0, instr[24:20]};
                        illegal = instr[25];
                    end else begin
                        fmt = FMT_I;
                        v   = i_imm;
                    end
                end
                OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                    fmt = FMT_I;
                    v   = i_imm;
                end
                OPC_STORE: begin
                    fmt = FMT_S;
                    v   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OPC_BRANCH: begin
                    fmt = FMT_B;
                    v   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt = FMT_U;
                    v   = {instr[31:12], 12'd0};
                end
                OPC_JAL: begin
                    fmt = FMT_J;
                    v   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
                        fmt = FMT_Z;
                        v   = {27'd0, instr[19:15]};
                    end else begin
                        fmt = FMT_I;
                        v   = i_imm;
                    end
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

    // Zero-extended values have bit 31 clear, so one sign extension covers both cases
    assign imm = {{(XLEN-31){v[31]}}, v[30:0]};

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with two-entry skid buffer
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_illegal;

    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    occ_state_e state_q;
    occ_state_e state_d;
    logic       accept;
    logic       drain;
    logic       load_main;
    logic       load_skid;
    logic       skid_to_main;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    assign load_main    = !flush && accept &&
                          ((state_q == OCC_EMPTY) || (state_q == OCC_ONE && drain));
    assign load_skid    = !flush && accept && (state_q == OCC_ONE) && !drain;
    assign skid_to_main = !flush && drain && (state_q == OCC_TWO);

    // Next occupancy from accept/drain; flush overrides every other event
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: if (accept) state_d = OCC_ONE;
            OCC_ONE: begin
                if (accept && !drain)      state_d = OCC_TWO;
                else if (!accept && drain) state_d = OCC_EMPTY;
            end
            OCC_TWO:   if (drain) state_d = OCC_ONE;
            default:   state_d = OCC_EMPTY;
        endcase
        if (flush) state_d = OCC_EMPTY;
    end

    // Occupancy register; valid/ready are flopped from the next state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCC_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d != OCC_EMPTY);
            in_ready  <= (state_d != OCC_TWO);
        end
    end

    // Main entry drives the outputs; refilled from the decoder or from the skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm     <= '0;
            out_fmt     <= FMT_NONE;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (load_main) begin
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_illegal;
            out_tag     <= in_tag;
        end else if (skid_to_main) begin
            out_imm     <= skid_imm;
            out_fmt     <= skid_fmt;
            out_illegal <= skid_illegal;
            out_tag     <= skid_tag;
        end
    end

    // Skid entry catches an accept while the main entry is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (load_skid) begin
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
            skid_tag     <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr  = 32'd0;
    logic [7:0]  in_tag    = 8'd0;

    logic        in_ready_32, out_valid_32, ill_32;
    logic [31:0] imm_32;
    logic [2:0]  fmt_32;
    logic [7:0]  tag_32;
    logic        in_ready_64, out_valid_64, ill_64;
    logic [63:0] imm_64;
    logic [2:0]  fmt_64;
    logic [7:0]  tag_64;

    int n_pass  = 0;
    int n_total = 0;
    int out_cnt = 0;
    bit mon_en  = 1'b0;
    bit prod_done;
    int w_a, w_b, c0, stalls;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  tag;
    } xfer_t;
    xfer_t q[$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] i32;
        logic [2:0]  f32;
        logic        l32;
        logic [63:0] i64;
        logic [2:0]  f64;
        logic        l64;
    } vec_t;
    vec_t vec[13];

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_32), .out_ready(out_ready), .out_imm(imm_32),
        .out_fmt(fmt_32), .out_illegal(ill_32), .out_tag(tag_32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_64), .out_ready(out_ready), .out_imm(imm_64),
        .out_fmt(fmt_64), .out_illegal(ill_64), .out_tag(tag_64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    endtask

    function automatic longint sgn(input longint u, input int n);
        return (u >= (longint'(1) << (n - 1))) ? u - (longint'(1) << n) : u;
    endfunction

    // Reference decode: immediates assembled arithmetically from the instruction fields
    function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint v;
        int     op, f3;
        bit     sh;
        op  = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        sh  = (f3 == 1) || (f3 == 5);
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        if (ins[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (op)
                'h33: v = 0;
                'h13: begin
                    if (sh) begin
                        fmt = 3'd7;
                        if (xlen == 64) v = longint'(ins[25:20]);
                        else begin v = longint'(ins[24:20]); ill = ins[25]; end
                    end else begin
                        fmt = 3'd1; v = sgn(longint'(ins[31:20]), 12);
                    end
                end
                'h1B: begin
                    if (xlen != 64) ill = 1'b1;
                    else if (sh) begin fmt = 3'd7; v = longint'(ins[24:20]); ill = ins[25]; end
                    else begin fmt = 3'd1; v = sgn(longint'(ins[31:20]), 12); end
                end
                'h03, 'h67, 'h0F: begin fmt = 3'd1; v = sgn(longint'(ins[31:20]), 12); end
                'h23: begin fmt = 3'd2; v = sgn(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); end
                'h63: begin
                    fmt = 3'd3;
                    v = sgn(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                            longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
                end
                'h37, 'h17: begin fmt = 3'd4; v = sgn(longint'(ins[31:12]) * 4096, 32); end
                'h6F: begin
                    fmt = 3'd5;
                    v = sgn(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                            longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
                end
                'h73: begin
                    if (f3 >= 5) begin fmt = 3'd6; v = longint'(ins[19:15]); end
                    else begin fmt = 3'd1; v = sgn(longint'(ins[31:20]), 12); end
                end
                default: ill = 1'b1;
            endcase
        end
        imm = 64'(v);
        if (xlen == 32) imm = {32'd0, imm[31:0]};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [0:12];
        int          k;
        ops = '{7'h33, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h0F, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h13};
        r = $urandom;
        k = int'($urandom_range(0, 13));
        if (k < 13) r[6:0] = ops[k];
        return r;
    endfunction

    // Scoreboard: occupancy, in-order output compare, then record this cycle's accept
    always @(negedge clk) begin
        xfer_t       e;
        logic [63:0] m_imm;
        logic [2:0]  m_fmt;
        logic        m_ill;
        if (!rst_n) begin
            q.delete();
        end else if (mon_en) begin
            chk("occ_out_valid32", 64'(out_valid_32), 64'(q.size() > 0));
            chk("occ_in_ready32",  64'(in_ready_32),  64'(q.size() < 2));
            chk("occ_out_valid64", 64'(out_valid_64), 64'(q.size() > 0));
            chk("occ_in_ready64",  64'(in_ready_64),  64'(q.size() < 2));
            if (out_valid_32 && out_ready && q.size() > 0) begin
                e = q.pop_front();
                out_cnt++;
                ref_dec(e.instr, 32, m_imm, m_fmt, m_ill);
                chk("sb_imm32", 64'(imm_32), m_imm);
                chk("sb_fmt32", 64'(fmt_32), 64'(m_fmt));
                chk("sb_ill32", 64'(ill_32), 64'(m_ill));
                chk("sb_tag32", 64'(tag_32), 64'(e.tag));
                ref_dec(e.instr, 64, m_imm, m_fmt, m_ill);
                chk("sb_imm64", imm_64, m_imm);
                chk("sb_fmt64", 64'(fmt_64), 64'(m_fmt));
                chk("sb_ill64", 64'(ill_64), 64'(m_ill));
                chk("sb_tag64", 64'(tag_64), 64'(e.tag));
            end
            if (flush) q.delete();
            else if (in_valid && in_ready_32) q.push_back('{in_instr, in_tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [7:0] tg, output int waits);
        logic ok;
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tg;
        waits    = 0;
        for (int guard = 0; guard < 400; guard++) begin
            @(negedge clk);
            ok = in_ready_32;
            tick();
            if (ok) break;
            waits++;
        end
        if (waits >= 400) begin
            n_total++;
            $display("FAIL send_timeout: instr %h not accepted after %0d cycles", ins, waits);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_out_valid32"}, 64'(out_valid_32), 64'd0);
        chk({name, "_in_ready32"},  64'(in_ready_32),  64'd1);
        chk({name, "_out_valid64"}, 64'(out_valid_64), 64'd0);
        chk({name, "_in_ready64"},  64'(in_ready_64),  64'd1);
    endtask

    task automatic chk_zero(input string name);
        chk_idle(name);
        chk({name, "_imm32"}, 64'(imm_32), 64'd0);
        chk({name, "_fmt32"}, 64'(fmt_32), 64'd0);
        chk({name, "_ill32"}, 64'(ill_32), 64'd0);
        chk({name, "_tag32"}, 64'(tag_32), 64'd0);
        chk({name, "_imm64"}, imm_64, 64'd0);
        chk({name, "_fmt64"}, 64'(fmt_64), 64'd0);
        chk({name, "_ill64"}, 64'(ill_64), 64'd0);
        chk({name, "_tag64"}, 64'(tag_64), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        vec[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
        vec[2]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0};
        vec[3]  = '{32'h300FD073, 32'h0000001F, 3'd6, 1'b0, 64'h000000000000001F, 3'd6, 1'b0};
        vec[4]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        vec[5]  = '{32'h03F09093, 32'h0000001F, 3'd7, 1'b1, 64'h000000000000003F, 3'd7, 1'b0};
        vec[6]  = '{32'h00000033, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
        vec[7]  = '{32'h0000001B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd1, 1'b0};
        vec[8]  = '{32'hFE112C23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
        vec[9]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
        vec[10] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
        vec[11] = '{32'h4010D093, 32'h00000001, 3'd7, 1'b0, 64'h0000000000000001, 3'd7, 1'b0};
        vec[12] = '{32'h00102573, 32'h00000001, 3'd1, 1'b0, 64'h0000000000000001, 3'd1, 1'b0};

        // Reset state
        repeat (3) tick();
        chk_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Table vectors: one instruction, visible the cycle after accept
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_instr = vec[i].instr;
            in_tag   = 8'(i + 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid32", i), 64'(out_valid_32), 64'd1);
            chk($sformatf("vec%0d_imm32", i),   64'(imm_32), 64'(vec[i].i32));
            chk($sformatf("vec%0d_fmt32", i),   64'(fmt_32), 64'(vec[i].f32));
            chk($sformatf("vec%0d_ill32", i),   64'(ill_32), 64'(vec[i].l32));
            chk($sformatf("vec%0d_tag32", i),   64'(tag_32), 64'(i + 1));
            chk($sformatf("vec%0d_imm64", i),   imm_64, vec[i].i64);
            chk($sformatf("vec%0d_fmt64", i),   64'(fmt_64), 64'(vec[i].f64));
            chk($sformatf("vec%0d_ill64", i),   64'(ill_64), 64'(vec[i].l64));
            tick();
        end

        // Backpressure: four instructions against a stalled consumer
        out_ready = 1'b0;
        c0 = out_cnt;
        fork
            begin
                for (int k = 0; k < 4; k++) send(rand_instr(), 8'(8'h40 + k), w_a);
            end
            begin
                tick();
                tick();
                chk("bp_in_ready_skid_full", 64'(in_ready_32), 64'd0);
                chk("bp_head_tag", 64'(tag_32), 64'h40);
                repeat (4) tick();
                chk("bp_in_ready_held", 64'(in_ready_32), 64'd0);
                chk("bp_head_tag_held", 64'(tag_32), 64'h40);
                out_ready = 1'b1;
            end
        join
        repeat (3) tick();
        chk("bp_count", 64'(out_cnt - c0), 64'd4);

        // Full throughput: sixteen back-to-back transfers
        c0 = out_cnt;
        stalls = 0;
        for (int k = 0; k < 16; k++) begin
            send(rand_instr(), 8'(k), w_a);
            stalls += w_a;
        end
        repeat (2) tick();
        chk("tp_stalls", 64'(stalls), 64'd0);
        chk("tp_count", 64'(out_cnt - c0), 64'd16);

        // Random traffic against random backpressure
        prod_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(rand_instr(), 8'($urandom), w_b);
                end
                prod_done = 1'b1;
            end
            begin
                for (int g = 0; g < 3000 && !prod_done; g++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) tick();
        chk("rand_drained", 64'(q.size()), 64'd0);

        // Flush with two held entries and a concurrent offer
        out_ready = 1'b0;
        c0 = out_cnt;
        send(32'hFFF00093, 8'hA0, w_a);
        send(32'h001000EF, 8'hA1, w_a);
        in_valid = 1'b1;
        in_instr = 32'h800000B7;
        in_tag   = 8'hA2;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_idle("flush2");
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush2_count", 64'(out_cnt - c0), 64'd0);

        // Flush in one-entry state discards a same-cycle accept
        out_ready = 1'b0;
        send(32'hFE000EE3, 8'hB0, w_a);
        in_valid = 1'b1;
        in_instr = 32'h300FD073;
        in_tag   = 8'hB1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_idle("flush1");
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush1_count", 64'(out_cnt - c0), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'hFFF00093, 8'hC0, w_a);
        send(32'h03F09093, 8'hC1, w_a);
        in_valid = 1'b1;
        in_instr = 32'h001000EF;
        #1 rst_n = 1'b0;
        #1;
        chk_zero("arst");
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk_idle("arst_after");
        out_ready = 1'b1;
        c0 = out_cnt;
        send(32'h4010D093, 8'hC2, w_a);
        repeat (2) tick();
        chk("arst_resume_count", 64'(out_cnt - c0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
